// File: rtl/riscv_datapath_pkg.sv
// Shared encodings for the RV32I single-cycle datapath: ALU operations,
// immediate formats and write-back selects.
package riscv_datapath_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_NREGS = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_IMM  = 2'b10,
    RES_ZERO = 2'b11
  } result_src_e;

endpackage

// File: rtl/riscv_regfile.sv
// 2-read/1-write architectural register file; x0 reads zero, reads are
// combinational with no write bypass, async active-low clear.
module riscv_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_datapath.sv
// Single-cycle RV32I integer datapath: register file, immediate extender,
// ALU and write-back select, steered by an external control unit.
module riscv_datapath
  import riscv_datapath_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int NREGS = RV_NREGS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ResultSrc,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic [1:0]      ImmSrc,
  input  logic [3:0]      ALUControl,
  input  logic [31:0]     Instr,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] WriteData,
  output logic            Zero
);

  logic [XLEN-1:0]        srca;
  logic [XLEN-1:0]        srcb;
  logic signed [XLEN-1:0] srca_s;
  logic signed [XLEN-1:0] srcb_s;
  logic [XLEN-1:0]        rs2_val;
  logic [XLEN-1:0]        imm_ext;
  logic [XLEN-1:0]        result;
  logic [4:0]             shamt;
  logic                   unused_opcode;

  // Opcode bits are decoded by the external control unit.
  assign unused_opcode = ^Instr[6:0];

  riscv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk (clk),
    .rst_n (reset),
    .we  (RegWrite),
    .ra1 (Instr[19:15]),
    .ra2 (Instr[24:20]),
    .wa  (Instr[11:7]),
    .wd  (result),
    .rd1 (srca),
    .rd2 (rs2_val)
  );

  always_comb begin
    imm_ext = '0;
    case (imm_src_e'(ImmSrc))
      IMM_I: imm_ext = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
      IMM_S: imm_ext = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B: imm_ext = {{(XLEN-12){Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-20){Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  assign srcb   = ALUSrc ? imm_ext : rs2_val;
  assign srca_s = srca;
  assign srcb_s = srcb;
  assign shamt  = srcb[4:0];

  always_comb begin
    ALUResult = '0;
    case (alu_op_e'(ALUControl))
      ALU_ADD:  ALUResult = srca + srcb;
      ALU_SUB:  ALUResult = srca - srcb;
      ALU_AND:  ALUResult = srca & srcb;
      ALU_OR:   ALUResult = srca | srcb;
      ALU_XOR:  ALUResult = srca ^ srcb;
      ALU_SLT:  ALUResult = {{(XLEN-1){1'b0}}, (srca_s < srcb_s)};
      ALU_SLTU: ALUResult = {{(XLEN-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  ALUResult = srca << shamt;
      ALU_SRL:  ALUResult = srca >> shamt;
      ALU_SRA:  ALUResult = srca_s >>> shamt;
      default:  ALUResult = '0;
    endcase
  end

  assign Zero      = (ALUResult == '0);
  assign WriteData = rs2_val;

  always_comb begin
    result = '0;
    case (result_src_e'(ResultSrc))
      RES_ALU:  result = ALUResult;
      RES_MEM:  result = ReadData;
      RES_IMM:  result = imm_ext;
      RES_ZERO: result = '0;
      default:  result = '0;
    endcase
  end

endmodule

// File: tb/tb_riscv_datapath.sv
// Directed bench for riscv_datapath: register writes, immediates, ALU ops,
// write-back sources and asynchronous clear.
module tb_riscv_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ResultSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] Instr;
  logic [31:0] ReadData;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        Zero;

  int tests = 0;
  int fails = 0;

  riscv_datapath dut (
    .clk        (clk),
    .reset      (reset),
    .ResultSrc  (ResultSrc),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Instr      (Instr),
    .ReadData   (ReadData),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic drive(input logic rw, input logic [1:0] rsrc, input logic asrc,
                       input logic [1:0] isrc, input logic [3:0] aluc, input logic [31:0] ins);
    RegWrite = rw; ResultSrc = rsrc; ALUSrc = asrc; ImmSrc = isrc; ALUControl = aluc; Instr = ins;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reads register r onto ALUResult via add rN,r,x0 with no write.
  task automatic read_reg(input logic [4:0] r);
    drive(1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, mk_r(5'd31, r, 5'd0));
  endtask

  task automatic test_reset();
    reset = 1'b0; ReadData = '0;
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00500093);
    tick(); tick();
    @(negedge clk); reset = 1'b1;
    read_reg(5'd1);
    tests++;
    if (ALUResult !== 32'h0) begin
      fails++; $display("FAIL reset_x1 got=%h exp=%h", ALUResult, 32'h0);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00500093);
    tests++;
    if (ALUResult !== 32'd5 || Zero !== 1'b0) begin
      fails++; $display("FAIL addi_comb got=%h/%b exp=00000005/0", ALUResult, Zero);
    end
    tick();
    drive(1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, mk_r(5'd2, 5'd1, 5'd0));
    tests++;
    if (ALUResult !== 32'd5) begin
      fails++; $display("FAIL addi_written got=%h exp=%h", ALUResult, 32'd5);
    end
  endtask

  task automatic test_neg_sub();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'hFFF00093);
    tests++;
    if (ALUResult !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL addi_neg got=%h exp=%h", ALUResult, 32'hFFFFFFFF);
    end
    tick();
    drive(1'b1, 2'b00, 1'b0, 2'b00, 4'b0001, mk_r(5'd3, 5'd1, 5'd1));
    tests++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      fails++; $display("FAIL sub_self got=%h/%b exp=00000000/1", ALUResult, Zero);
    end
    tick();
  endtask

  task automatic test_x0_write();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00700013);
    tests++;
    if (ALUResult !== 32'd7) begin
      fails++; $display("FAIL x0_addi_comb got=%h exp=%h", ALUResult, 32'd7);
    end
    tick();
    drive(1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, mk_r(5'd4, 5'd0, 5'd0));
    tests++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      fails++; $display("FAIL x0_read got=%h/%b exp=00000000/1", ALUResult, Zero);
    end
    tick();
  endtask

  task automatic test_load_store();
    ReadData = 32'hDEADBEEF;
    drive(1'b1, 2'b01, 1'b1, 2'b00, 4'b0000, 32'h00002283);
    tick();
    ReadData = 32'h0;
    read_reg(5'd5);
    tests++;
    if (ALUResult !== 32'hDEADBEEF) begin
      fails++; $display("FAIL load_wb got=%h exp=%h", ALUResult, 32'hDEADBEEF);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b01, 4'b0000,
          {7'h7F, 5'd5, 5'd0, 3'b010, 5'b11100, 7'b0100011});
    tests++;
    if (ALUResult !== 32'hFFFFFFFC || WriteData !== 32'hDEADBEEF) begin
      fails++; $display("FAIL store_s got=%h/%h exp=FFFFFFFC/DEADBEEF", ALUResult, WriteData);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [11];
    logic [31:0] exp [11];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};
    exp = '{32'hFFFFFFFA, 32'hFFFFFFF6, 32'h00000000, 32'hFFFFFFFA, 32'hFFFFFFFA,
            32'h00000001, 32'h00000000, 32'hFFFFFFE0, 32'h3FFFFFFE, 32'hFFFFFFFE,
            32'h00000000};
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'hFF800093);
    tick();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00200113);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 2'b00, 1'b0, 2'b00, ops[i], mk_r(5'd9, 5'd1, 5'd2));
      tests++;
      if (ALUResult !== exp[i] || Zero !== (exp[i] == 32'h0)) begin
        fails++;
        $display("FAIL alu_op_%b got=%h/%b exp=%h/%b", ops[i], ALUResult, Zero,
                 exp[i], (exp[i] == 32'h0));
      end
    end
    drive(1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, mk_r(5'd9, 5'd2, 5'd1));
    tests++;
    if (WriteData !== 32'hFFFFFFF8) begin
      fails++; $display("FAIL writedata got=%h exp=%h", WriteData, 32'hFFFFFFF8);
    end
  endtask

  task automatic test_immediates();
    drive(1'b0, 2'b00, 1'b1, 2'b10, 4'b0000,
          {1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b1100, 1'b1, 7'h63});
    tests++;
    if (ALUResult !== 32'hFFFFFFF8) begin
      fails++; $display("FAIL imm_b_neg got=%h exp=%h", ALUResult, 32'hFFFFFFF8);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b10, 4'b0000,
          {1'b0, 6'b000000, 5'd0, 5'd0, 3'b000, 4'b1000, 1'b0, 7'h63});
    tests++;
    if (ALUResult !== 32'h00000010) begin
      fails++; $display("FAIL imm_b_pos got=%h exp=%h", ALUResult, 32'h10);
    end
    drive(1'b0, 2'b00, 1'b1, 2'b11, 4'b0000,
          {1'b0, 10'b0, 1'b1, 8'h00, 5'd7, 7'h6F});
    tests++;
    if (ALUResult !== 32'h00000800) begin
      fails++; $display("FAIL imm_j_pos got=%h exp=%h", ALUResult, 32'h800);
    end
    drive(1'b1, 2'b10, 1'b1, 2'b11, 4'b0000,
          {1'b1, 10'b1111111110, 1'b1, 8'hFF, 5'd7, 7'h6F});
    tick();
    read_reg(5'd7);
    tests++;
    if (ALUResult !== 32'hFFFFFFFC) begin
      fails++; $display("FAIL imm_j_wb got=%h exp=%h", ALUResult, 32'hFFFFFFFC);
    end
    drive(1'b1, 2'b11, 1'b1, 2'b00, 4'b0000, mk_i(5'd7, 5'd0, 12'h123));
    tick();
    read_reg(5'd7);
    tests++;
    if (ALUResult !== 32'h0) begin
      fails++; $display("FAIL wb_zero got=%h exp=%h", ALUResult, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00500093);
    tick();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, mk_i(5'd1, 5'd1, 12'd1));
    tests++;
    if (ALUResult !== 32'd6) begin
      fails++; $display("FAIL rdw_before got=%h exp=%h", ALUResult, 32'd6);
    end
    tick();
    tests++;
    if (ALUResult !== 32'd7) begin
      fails++; $display("FAIL rdw_after got=%h exp=%h", ALUResult, 32'd7);
    end
    tick();
    RegWrite = 1'b0;
    #1;
    tests++;
    if (ALUResult !== 32'd8) begin
      fails++; $display("FAIL rdw_third got=%h exp=%h", ALUResult, 32'd8);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00500093);
    tick();
    read_reg(5'd1);
    tests++;
    if (ALUResult !== 32'd5) begin
      fails++; $display("FAIL arst_pre got=%h exp=%h", ALUResult, 32'd5);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (ALUResult !== 32'h0 || Zero !== 1'b1) begin
      fails++; $display("FAIL arst_immediate got=%h/%b exp=00000000/1", ALUResult, Zero);
    end
    drive(1'b1, 2'b00, 1'b1, 2'b00, 4'b0000, 32'h00500093);
    tick(); tick();
    @(negedge clk); reset = 1'b1;
    read_reg(5'd1);
    tests++;
    if (ALUResult !== 32'h0) begin
      fails++; $display("FAIL arst_blocked got=%h exp=%h", ALUResult, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_neg_sub();
    test_x0_write();
    test_load_store();
    test_alu_ops();
    test_immediates();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
